// File: rtl/pspin_ingress_pkg.sv
// Shared types and default configuration for the ingress descriptor arbiter.
// The typedefs describe the default build; parameterised modules derive their own widths.
package pspin_ingress_pkg;

  localparam int unsigned DEF_NUM_SRC         = 4;
  localparam int unsigned DEF_AXI_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_LEN_WIDTH       = 20;
  localparam int unsigned DEF_TAG_WIDTH       = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 8;

  // Source index occupies the top SRC_W bits of the downstream tag.
  localparam int unsigned SRC_W       = $clog2(DEF_NUM_SRC);
  localparam int unsigned SRC_TAG_LSB = DEF_TAG_WIDTH - SRC_W;
  localparam int unsigned CNT_W       = $clog2(DEF_MAX_OUTSTANDING + 1);

  typedef logic [SRC_W-1:0] src_idx_t;
  typedef logic [CNT_W-1:0] credit_cnt_t;

endpackage

// File: rtl/pspin_ingress_desc_arb_if.sv
// Descriptor and completion bus bundle between allocators, arbiter and ingress DMA.
// master = arbiter view, slave = surrounding fabric view.
interface pspin_ingress_desc_arb_if
  import pspin_ingress_pkg::*;
#(
  parameter  int unsigned NUM_SRC        = DEF_NUM_SRC,
  parameter  int unsigned AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
  parameter  int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter  int unsigned TAG_WIDTH      = DEF_TAG_WIDTH,
  localparam int unsigned SRC_W          = $clog2(NUM_SRC),
  localparam int unsigned SRC_TAG_W      = TAG_WIDTH - SRC_W
);

  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0] s_desc_addr;
  logic [NUM_SRC*LEN_WIDTH-1:0]      s_desc_len;
  logic [NUM_SRC*SRC_TAG_W-1:0]      s_desc_tag;
  logic [NUM_SRC-1:0]                s_desc_valid;
  logic [NUM_SRC-1:0]                s_desc_ready;

  logic [AXI_ADDR_WIDTH-1:0]         m_desc_addr;
  logic [LEN_WIDTH-1:0]              m_desc_len;
  logic [TAG_WIDTH-1:0]              m_desc_tag;
  logic                              m_desc_valid;
  logic                              m_desc_ready;

  logic [AXI_ADDR_WIDTH-1:0]         s_cpl_addr;
  logic [LEN_WIDTH-1:0]              s_cpl_len;
  logic [TAG_WIDTH-1:0]              s_cpl_tag;
  logic                              s_cpl_valid;
  logic                              s_cpl_ready;

  logic [AXI_ADDR_WIDTH-1:0]         m_cpl_addr;
  logic [LEN_WIDTH-1:0]              m_cpl_len;
  logic [SRC_TAG_W-1:0]              m_cpl_tag;
  logic [NUM_SRC-1:0]                m_cpl_valid;
  logic [NUM_SRC-1:0]                m_cpl_ready;

  modport master (
    input  s_desc_addr, s_desc_len, s_desc_tag, s_desc_valid,
    output s_desc_ready,
    output m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
    input  m_desc_ready,
    input  s_cpl_addr, s_cpl_len, s_cpl_tag, s_cpl_valid,
    output s_cpl_ready,
    output m_cpl_addr, m_cpl_len, m_cpl_tag, m_cpl_valid,
    input  m_cpl_ready
  );

  modport slave (
    output s_desc_addr, s_desc_len, s_desc_tag, s_desc_valid,
    input  s_desc_ready,
    input  m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
    output m_desc_ready,
    output s_cpl_addr, s_cpl_len, s_cpl_tag, s_cpl_valid,
    input  s_cpl_ready,
    input  m_cpl_addr, m_cpl_len, m_cpl_tag, m_cpl_valid,
    output m_cpl_ready
  );

endinterface

// File: rtl/pspin_rr_arbiter.sv
// Round-robin picker: combinational first-request-at-or-after pointer,
// pointer moves past the winner when advance is asserted.
module pspin_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters starting from the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found        = 1'b0;
    cand         = '0;
    grant_onehot = '0;
    grant_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pspin_ingress_desc_arb.sv
// Shares the ingress DMA write-descriptor channel between allocator sources with
// round-robin arbitration and per-source credits; routes completions back by tag.
module pspin_ingress_desc_arb
  import pspin_ingress_pkg::*;
#(
  parameter  int unsigned NUM_SRC         = DEF_NUM_SRC,
  parameter  int unsigned AXI_ADDR_WIDTH  = DEF_AXI_ADDR_WIDTH,
  parameter  int unsigned LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter  int unsigned TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter  int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int unsigned SRC_W           = $clog2(NUM_SRC),
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned SRC_TAG_W       = TAG_WIDTH - SRC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  pspin_ingress_desc_arb_if.master   bus,
  output logic [NUM_SRC*CNT_W-1:0]   outstanding,
  output logic                       err_cpl
);

  logic [CNT_W-1:0]          cnt_q [NUM_SRC];
  logic [CNT_W-1:0]          cnt_d [NUM_SRC];

  logic                      m_desc_valid_q, m_desc_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] m_desc_addr_q, m_desc_addr_d;
  logic [LEN_WIDTH-1:0]      m_desc_len_q, m_desc_len_d;
  logic [TAG_WIDTH-1:0]      m_desc_tag_q, m_desc_tag_d;

  logic [NUM_SRC-1:0]        m_cpl_valid_q, m_cpl_valid_d;
  logic [SRC_W-1:0]          cpl_src_q, cpl_src_d;
  logic [AXI_ADDR_WIDTH-1:0] m_cpl_addr_q, m_cpl_addr_d;
  logic [LEN_WIDTH-1:0]      m_cpl_len_q, m_cpl_len_d;
  logic [SRC_TAG_W-1:0]      m_cpl_tag_q, m_cpl_tag_d;
  logic                      err_cpl_q, err_cpl_d;

  logic [NUM_SRC-1:0]        eligible_c;
  logic [NUM_SRC-1:0]        req_c;
  logic [NUM_SRC-1:0]        grant_onehot_c;
  logic [SRC_W-1:0]          grant_idx_c;
  logic                      load_c;
  logic                      desc_fire_c;
  logic [SRC_W-1:0]          cpl_idx_c;
  logic                      idx_ok_c;
  logic                      s_cpl_ready_c;
  logic                      cpl_fire_c;
  logic [NUM_SRC-1:0]        inc_c;
  logic [NUM_SRC-1:0]        dec_c;

  // Descriptor issue: credit check, then round-robin among eligible sources.
  always_comb begin
    eligible_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      eligible_c[i] = bus.s_desc_valid[i] & enable & (32'(cnt_q[i]) < MAX_OUTSTANDING);
    end
  end

  assign load_c      = !m_desc_valid_q || bus.m_desc_ready;
  assign req_c       = (rst || !load_c) ? '0 : eligible_c;
  assign desc_fire_c = |grant_onehot_c;

  pspin_rr_arbiter #(
    .NUM_REQ (NUM_SRC)
  ) u_rr_arbiter (
    .clk          (clk),
    .rst          (rst),
    .req          (req_c),
    .advance      (desc_fire_c),
    .grant_onehot (grant_onehot_c),
    .grant_idx    (grant_idx_c)
  );

  always_comb begin
    m_desc_valid_d = m_desc_valid_q;
    m_desc_addr_d  = m_desc_addr_q;
    m_desc_len_d   = m_desc_len_q;
    m_desc_tag_d   = m_desc_tag_q;
    if (desc_fire_c) begin
      m_desc_valid_d = 1'b1;
      m_desc_addr_d  = bus.s_desc_addr[32'(grant_idx_c)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      m_desc_len_d   = bus.s_desc_len[32'(grant_idx_c)*LEN_WIDTH +: LEN_WIDTH];
      m_desc_tag_d   = {grant_idx_c, bus.s_desc_tag[32'(grant_idx_c)*SRC_TAG_W +: SRC_TAG_W]};
    end else if (bus.m_desc_ready) begin
      m_desc_valid_d = 1'b0;
    end
  end

  // Completion routing: the top tag bits name the owning source.
  assign cpl_idx_c = bus.s_cpl_tag[TAG_WIDTH-1 -: SRC_W];

  if (NUM_SRC == (1 << SRC_W)) begin : g_idx_pow2
    assign idx_ok_c = 1'b1;
  end else begin : g_idx_range
    assign idx_ok_c = (32'(cpl_idx_c) < NUM_SRC);
  end

  assign s_cpl_ready_c = !rst && (!(|m_cpl_valid_q) || bus.m_cpl_ready[cpl_src_q]);
  assign cpl_fire_c    = bus.s_cpl_valid && s_cpl_ready_c;

  always_comb begin
    m_cpl_valid_d = m_cpl_valid_q;
    cpl_src_d     = cpl_src_q;
    m_cpl_addr_d  = m_cpl_addr_q;
    m_cpl_len_d   = m_cpl_len_q;
    m_cpl_tag_d   = m_cpl_tag_q;
    err_cpl_d     = err_cpl_q;
    if (cpl_fire_c) begin
      m_cpl_valid_d = '0;
      if (idx_ok_c) begin
        m_cpl_valid_d[cpl_idx_c] = 1'b1;
        cpl_src_d                = cpl_idx_c;
        m_cpl_addr_d             = bus.s_cpl_addr;
        m_cpl_len_d              = bus.s_cpl_len;
        m_cpl_tag_d              = bus.s_cpl_tag[SRC_TAG_W-1:0];
        if (cnt_q[cpl_idx_c] == '0) begin
          err_cpl_d = 1'b1;
        end
      end else begin
        err_cpl_d = 1'b1;
      end
    end else if ((|m_cpl_valid_q) && bus.m_cpl_ready[cpl_src_q]) begin
      m_cpl_valid_d = '0;
    end
  end

  // Credit counters; a zero count is never decremented, a full one is never granted.
  always_comb begin
    inc_c = '0;
    dec_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      inc_c[i] = desc_fire_c & grant_onehot_c[i];
      dec_c[i] = cpl_fire_c & idx_ok_c & (32'(cpl_idx_c) == i) & (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i] + CNT_W'(inc_c[i]) - CNT_W'(dec_c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_desc_valid_q <= 1'b0;
      m_desc_addr_q  <= '0;
      m_desc_len_q   <= '0;
      m_desc_tag_q   <= '0;
      m_cpl_valid_q  <= '0;
      cpl_src_q      <= '0;
      m_cpl_addr_q   <= '0;
      m_cpl_len_q    <= '0;
      m_cpl_tag_q    <= '0;
      err_cpl_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      m_desc_valid_q <= m_desc_valid_d;
      m_desc_addr_q  <= m_desc_addr_d;
      m_desc_len_q   <= m_desc_len_d;
      m_desc_tag_q   <= m_desc_tag_d;
      m_cpl_valid_q  <= m_cpl_valid_d;
      cpl_src_q      <= cpl_src_d;
      m_cpl_addr_q   <= m_cpl_addr_d;
      m_cpl_len_q    <= m_cpl_len_d;
      m_cpl_tag_q    <= m_cpl_tag_d;
      err_cpl_q      <= err_cpl_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.s_desc_ready = grant_onehot_c;
  assign bus.m_desc_valid = m_desc_valid_q;
  assign bus.m_desc_addr  = m_desc_addr_q;
  assign bus.m_desc_len   = m_desc_len_q;
  assign bus.m_desc_tag   = m_desc_tag_q;
  assign bus.s_cpl_ready  = s_cpl_ready_c;
  assign bus.m_cpl_valid  = m_cpl_valid_q;
  assign bus.m_cpl_addr   = m_cpl_addr_q;
  assign bus.m_cpl_len    = m_cpl_len_q;
  assign bus.m_cpl_tag    = m_cpl_tag_q;
  assign err_cpl          = err_cpl_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_outstanding
    assign outstanding[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_pspin_ingress_desc_arb.sv
// Directed bench for pspin_ingress_desc_arb: a vector table for arbitration
// and credits, plus hand sequences for completions, errors, stalls and reset.
module tb_pspin_ingress_desc_arb;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 20;
  localparam int unsigned TW = 32;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [NS*CW-1:0] outstanding;
  logic           err_cpl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] src_addr [NS] = '{32'h2000, 32'h3000, 32'h1000, 32'h4000};
  logic [19:0] src_len  [NS] = '{20'd16, 20'd32, 20'd64, 20'd128};
  logic [29:0] src_tag  [NS] = '{30'h11, 30'h22, 30'h5, 30'h33};

  typedef struct {
    logic [3:0] valid;
    logic       en;
    logic       mrdy;
    logic [3:0] exp_rdy;
    logic       exp_mv;
    int         exp_src;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [12];

  pspin_ingress_desc_arb_if #(
    .NUM_SRC(NS), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)
  ) bus ();

  pspin_ingress_desc_arb #(
    .NUM_SRC(NS), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .outstanding (outstanding),
    .err_cpl     (err_cpl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] full_tag(input int s);
    logic [1:0] idx;
    idx = s[1:0];
    return {idx, src_tag[s]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Round-robin sweep from reset; MAX_OUTSTANDING=2 so every source fills after two grants.
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 0, 8'h01};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 1, 8'h05};
    tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2, 8'h15};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 3, 8'h55};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 3, 8'h55};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 3, 8'h55};
    tbl[6]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 3, 8'h55};
    tbl[7]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2, 8'h65};
    tbl[8]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 3, 8'hA5};
    tbl[9]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 0, 8'hA6};
    tbl[10] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 1, 8'hAA};
    tbl[11] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 1, 8'hAA};

    rst              = 1'b1;
    enable           = 1'b0;
    bus.s_desc_valid = '0;
    bus.m_desc_ready = 1'b0;
    bus.s_cpl_valid  = 1'b0;
    bus.s_cpl_addr   = '0;
    bus.s_cpl_len    = '0;
    bus.s_cpl_tag    = '0;
    bus.m_cpl_ready  = '0;
    for (int i = 0; i < NS; i++) begin
      bus.s_desc_addr[i*AW +: AW] = src_addr[i];
      bus.s_desc_len[i*LW +: LW]  = src_len[i];
      bus.s_desc_tag[i*30 +: 30]  = src_tag[i];
    end
    tick();
    tick();
    chk("rst_m_desc_valid", 64'(bus.m_desc_valid), 64'd0);
    chk("rst_m_cpl_valid", 64'(bus.m_cpl_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err_cpl", 64'(err_cpl), 64'd0);
    chk("rst_m_desc_tag", 64'(bus.m_desc_tag), 64'd0);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      bus.s_desc_valid = tbl[r].valid;
      enable           = tbl[r].en;
      bus.m_desc_ready = tbl[r].mrdy;
      #1;
      chk($sformatf("row%0d_s_desc_ready", r), 64'(bus.s_desc_ready), 64'(tbl[r].exp_rdy));
      tick();
      chk($sformatf("row%0d_m_desc_valid", r), 64'(bus.m_desc_valid), 64'(tbl[r].exp_mv));
      chk($sformatf("row%0d_m_desc_tag", r), 64'(bus.m_desc_tag), 64'(full_tag(tbl[r].exp_src)));
      chk($sformatf("row%0d_m_desc_addr", r), 64'(bus.m_desc_addr), 64'(src_addr[tbl[r].exp_src]));
      chk($sformatf("row%0d_m_desc_len", r), 64'(bus.m_desc_len), 64'(src_len[tbl[r].exp_src]));
      chk($sformatf("row%0d_outstanding", r), 64'(outstanding), 64'(tbl[r].exp_cnt));
    end

    // Credit return on a full source 1 allows exactly one more grant.
    bus.s_desc_valid = 4'b0010;
    enable           = 1'b1;
    bus.m_desc_ready = 1'b1;
    bus.s_cpl_valid  = 1'b1;
    bus.s_cpl_tag    = 32'h4000_0022;
    bus.s_cpl_addr   = 32'hAAAA_0000;
    bus.s_cpl_len    = 20'h123;
    bus.m_cpl_ready  = 4'b0000;
    #1;
    chk("credit_full_no_ready", 64'(bus.s_desc_ready), 64'd0);
    chk("cpl_ready_idle", 64'(bus.s_cpl_ready), 64'd1);
    tick();
    bus.s_cpl_valid = 1'b0;
    chk("credit_cpl_valid", 64'(bus.m_cpl_valid), 64'b0010);
    chk("credit_cpl_tag", 64'(bus.m_cpl_tag), 64'h22);
    chk("credit_cpl_addr", 64'(bus.m_cpl_addr), 64'hAAAA_0000);
    chk("credit_cpl_len", 64'(bus.m_cpl_len), 64'h123);
    chk("credit_cnt_dec", 64'(outstanding), 64'hA6);
    #1;
    chk("credit_regrant", 64'(bus.s_desc_ready), 64'b0010);
    tick();
    chk("credit_cnt_refill", 64'(outstanding), 64'hAA);
    chk("credit_desc_tag", 64'(bus.m_desc_tag), 64'h4000_0022);
    bus.m_cpl_ready = 4'b1101;
    #1;
    chk("credit_one_grant_only", 64'(bus.s_desc_ready), 64'd0);
    chk("cpl_other_ready_ignored", 64'(bus.s_cpl_ready), 64'd0);
    tick();
    chk("cpl_held", 64'(bus.m_cpl_valid), 64'b0010);
    chk("desc_valid_drops", 64'(bus.m_desc_valid), 64'd0);
    bus.m_cpl_ready = 4'b0010;
    #1;
    chk("cpl_ready_matching", 64'(bus.s_cpl_ready), 64'd1);
    tick();
    chk("cpl_drained", 64'(bus.m_cpl_valid), 64'd0);

    // Source 3 down to one credit, then grant and completion in the same cycle.
    bus.s_desc_valid = 4'b0000;
    bus.s_cpl_valid  = 1'b1;
    bus.s_cpl_tag    = 32'hC000_0033;
    bus.s_cpl_addr   = 32'hBBBB_0000;
    bus.s_cpl_len    = 20'd7;
    bus.m_cpl_ready  = 4'b1000;
    tick();
    chk("s3_cnt_one", 64'(outstanding), 64'h6A);
    chk("s3_cpl_valid", 64'(bus.m_cpl_valid), 64'b1000);
    bus.s_desc_valid = 4'b1000;
    bus.s_cpl_addr   = 32'hCCCC_0000;
    #1;
    chk("s3_same_cycle_grant", 64'(bus.s_desc_ready), 64'b1000);
    chk("s3_same_cycle_cpl_ready", 64'(bus.s_cpl_ready), 64'd1);
    tick();
    chk("s3_net_zero", 64'(outstanding), 64'h6A);
    chk("s3_desc_tag", 64'(bus.m_desc_tag), 64'hC000_0033);
    chk("s3_cpl_addr", 64'(bus.m_cpl_addr), 64'hCCCC_0000);
    chk("s3_no_err", 64'(err_cpl), 64'd0);

    // Grants disabled, completions still drain.
    enable           = 1'b0;
    bus.s_desc_valid = 4'b1111;
    bus.s_cpl_tag    = 32'h0000_0011;
    bus.s_cpl_addr   = 32'hDDDD_0000;
    #1;
    chk("dis_no_grant", 64'(bus.s_desc_ready), 64'd0);
    chk("dis_cpl_ready", 64'(bus.s_cpl_ready), 64'd1);
    tick();
    chk("dis_cpl_valid", 64'(bus.m_cpl_valid), 64'b0001);
    chk("dis_cnt", 64'(outstanding), 64'h69);
    chk("dis_desc_drained", 64'(bus.m_desc_valid), 64'd0);

    // Two more completions for source 0: the second finds a zero count.
    enable           = 1'b1;
    bus.s_desc_valid = 4'b0000;
    bus.m_cpl_ready  = 4'b0001;
    tick();
    chk("err_cnt_zero", 64'(outstanding), 64'h68);
    chk("err_not_yet", 64'(err_cpl), 64'd0);
    tick();
    bus.s_cpl_valid = 1'b0;
    chk("err_cnt_stays", 64'(outstanding), 64'h68);
    chk("err_set", 64'(err_cpl), 64'd1);
    chk("err_cpl_forwarded", 64'(bus.m_cpl_valid), 64'b0001);

    // Downstream stall holds the descriptor for five cycles.
    bus.s_desc_valid = 4'b0001;
    bus.m_desc_ready = 1'b0;
    bus.m_cpl_ready  = 4'b0000;
    #1;
    chk("stall_first_grant", 64'(bus.s_desc_ready), 64'b0001);
    tick();
    chk("stall_valid", 64'(bus.m_desc_valid), 64'd1);
    chk("stall_cnt0", 64'(outstanding), 64'h69);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d_no_ready", k), 64'(bus.s_desc_ready), 64'd0);
      tick();
      chk($sformatf("stall%0d_valid", k), 64'(bus.m_desc_valid), 64'd1);
      chk($sformatf("stall%0d_tag", k), 64'(bus.m_desc_tag), 64'h0000_0011);
      chk($sformatf("stall%0d_addr", k), 64'(bus.m_desc_addr), 64'h2000);
      chk($sformatf("stall%0d_len", k), 64'(bus.m_desc_len), 64'd16);
      chk($sformatf("stall%0d_cnt", k), 64'(outstanding), 64'h69);
    end

    // Reset mid-transfer: no handshake in the reset cycle, everything cleared.
    rst              = 1'b1;
    bus.m_desc_ready = 1'b1;
    bus.s_cpl_valid  = 1'b1;
    #1;
    chk("rst_cycle_desc_ready", 64'(bus.s_desc_ready), 64'd0);
    chk("rst_cycle_cpl_ready", 64'(bus.s_cpl_ready), 64'd0);
    tick();
    chk("rst2_m_desc_valid", 64'(bus.m_desc_valid), 64'd0);
    chk("rst2_m_cpl_valid", 64'(bus.m_cpl_valid), 64'd0);
    chk("rst2_outstanding", 64'(outstanding), 64'd0);
    chk("rst2_err_cpl", 64'(err_cpl), 64'd0);
    chk("rst2_m_desc_tag", 64'(bus.m_desc_tag), 64'd0);
    chk("rst2_m_cpl_addr", 64'(bus.m_cpl_addr), 64'd0);
    rst              = 1'b0;
    bus.s_cpl_valid  = 1'b0;
    bus.s_desc_valid = 4'b0000;

    // Single source 2 round trip with tag stamping.
    bus.s_desc_valid = 4'b0100;
    #1;
    chk("s2_ready", 64'(bus.s_desc_ready), 64'b0100);
    tick();
    chk("s2_tag", 64'(bus.m_desc_tag), 64'h8000_0005);
    chk("s2_addr", 64'(bus.m_desc_addr), 64'h1000);
    chk("s2_len", 64'(bus.m_desc_len), 64'd64);
    chk("s2_cnt", 64'(outstanding), 64'h10);
    bus.s_desc_valid = 4'b0000;
    bus.s_cpl_valid  = 1'b1;
    bus.s_cpl_tag    = 32'h8000_0005;
    bus.s_cpl_addr   = 32'h1000;
    bus.s_cpl_len    = 20'd64;
    bus.m_cpl_ready  = 4'b0100;
    tick();
    bus.s_cpl_valid = 1'b0;
    chk("s2_cpl_valid", 64'(bus.m_cpl_valid), 64'b0100);
    chk("s2_cpl_tag", 64'(bus.m_cpl_tag), 64'h5);
    chk("s2_cnt_back", 64'(outstanding), 64'd0);
    chk("s2_no_err", 64'(err_cpl), 64'd0);
    tick();
    chk("s2_cpl_done", 64'(bus.m_cpl_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
